// File: rtl/leb128_enc_stream.sv
// Streaming LEB128 encoder: one WIDTH-bit word in, its LEB128 bytes out one per cycle on a valid/ready stream.
// Define LEB128_SIGNED_EN for SLEB128 (signed) encoding; the default build encodes unsigned LEB128.
module leb128_enc_stream #(
  parameter int WIDTH = 32,
  localparam int N = (WIDTH + 6) / 7,
  localparam int LW = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] idata,
  input  logic             ivalid,
  output logic             iready,
  output logic [7:0]       odata,
  output logic             ovalid,
  input  logic             oready,
  output logic             olast,
  output logic [LW-1:0]    olen
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_shNext;
  logic [LW-1:0]    r_rem;
  logic [LW-1:0]    r_olen;
  logic [LW-1:0]    w_len;
  logic             w_take;
  logic             w_fire;

  assign w_take = ivalid & iready;
  assign w_fire = ovalid & oready;
  assign olen   = r_olen;

`ifdef LEB128_SIGNED_EN
  // A word needs n+1 bytes when the bits above position 7n-1 are not a pure sign extension.
  always_comb begin
    logic [WIDTH-1:0] top;
    top   = '0;
    w_len = LW'(1);
    for (int n = 1; n < N; n++) begin
      top = WIDTH'($signed(idata) >>> (7 * n - 1));
      if ((top != '0) && (top != '1)) w_len = LW'(n + 1);
    end
  end

  assign w_shNext = WIDTH'($signed(r_sh) >>> 7);
`else
  always_comb begin
    w_len = LW'(1);
    for (int n = 1; n < N; n++) begin
      if ((idata >> (7 * n)) != '0) w_len = LW'(n + 1);
    end
  end

  assign w_shNext = r_sh >> 7;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A new word taken alongside the final byte keeps us in EMIT with no bubble.
  always_comb begin
    w_next = r_state;
    if (w_take)              w_next = EMIT;
    else if (w_fire && olast) w_next = IDLE;
  end

  always_comb begin
    ovalid = 1'b0;
    olast  = 1'b0;
    odata  = 8'h00;
    if (r_state == EMIT) begin
      ovalid = 1'b1;
      olast  = (r_rem == LW'(1));
      odata  = {(r_rem != LW'(1)), r_sh[6:0]};
    end
    iready = (r_state == IDLE) | (ovalid & olast & oready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh   <= '0;
      r_rem  <= '0;
      r_olen <= '0;
    end else if (w_take) begin
      r_sh   <= idata;
      r_rem  <= w_len;
      r_olen <= w_len;
    end else if (w_fire) begin
      r_sh   <= w_shNext;
      r_rem  <= r_rem - LW'(1);
    end
  end

endmodule

// File: tb/tb_leb128_enc_stream.sv
// Scoreboard bench for leb128_enc_stream (WIDTH = 32); follows LEB128_SIGNED_EN to pick the reference encoding.
module tb_leb128_enc_stream;

  localparam int WIDTH = 32;
  localparam int LW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] idata;
  logic             ivalid;
  logic             iready;
  logic [7:0]       odata;
  logic             ovalid;
  logic             oready;
  logic             olast;
  logic [LW-1:0]    olen;

  typedef struct {
    logic [7:0]    b;
    logic          last;
    logic [LW-1:0] len;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] wordQ[$];
  int          total = 0;
  int          bad = 0;
  int          wordCount = 0;
  int          lastCount = 0;
  int          oreadyMode = 0;
  longint unsigned decAcc = 0;
  int          decShift = 0;
  logic        stallPrev = 1'b0;
  logic [15:0] prevBundle = '0;

  leb128_enc_stream #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .iready(iready),
    .odata(odata), .ovalid(ovalid), .oready(oready), .olast(olast), .olen(olen)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: classic loop form, independent of the length search in the design.
  task automatic pushExpected(input logic [31:0] v);
    logic [7:0] bytes[8];
    int         n;
    logic       done;
    longint     x;
    n = 0;
`ifdef LEB128_SIGNED_EN
    x = longint'($signed(v));
`else
    x = longint'({32'b0, v});
`endif
    do begin
      bytes[n] = {1'b0, x[6:0]};
`ifdef LEB128_SIGNED_EN
      x = x >>> 7;
      done = (x == 0 && !bytes[n][6]) || (x == -1 && bytes[n][6]);
`else
      x = x >> 7;
      done = (x == 0);
`endif
      if (!done) bytes[n][7] = 1'b1;
      n++;
    end while (!done);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.b    = bytes[k];
      e.last = (k == n - 1);
      e.len  = LW'(n);
      expQ.push_back(e);
    end
    wordQ.push_back(v);
    wordCount++;
  endtask

  // Monitor: everything sampled on the falling edge, before the rising edge that commits it.
  always @(negedge clk) begin
    if (rst) begin
      if (expQ.size() != 0) wordCount--;
      expQ.delete();
      wordQ.delete();
      decAcc    = 0;
      decShift  = 0;
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("hold_ovalid", ovalid, 1);
        checkOutput("hold_bundle", {olast, 4'b0, olen, odata}, prevBundle);
      end
      checkOutput("iready_rule", iready, (!ovalid) || (olast && oready));
      if (ovalid && oready) begin
        checkOutput("byte_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("sb_odata", odata, e.b);
          checkOutput("sb_olast", olast, e.last);
          checkOutput("sb_olen", olen, e.len);
        end
        decAcc   = decAcc | (longint'(odata[6:0]) << decShift);
        decShift = decShift + 7;
        if (olast) begin
          logic [31:0] w;
          longint unsigned want;
          lastCount++;
`ifdef LEB128_SIGNED_EN
          if (odata[6] && decShift < 64) decAcc = decAcc | (~64'd0 << decShift);
`endif
          if (wordQ.size() != 0) begin
            w = wordQ.pop_front();
`ifdef LEB128_SIGNED_EN
            want = longint'($signed(w));
`else
            want = {32'b0, w};
`endif
            checkOutput("decode", decAcc, want);
          end
          decAcc   = 0;
          decShift = 0;
        end
      end
      if (ivalid && iready) pushExpected(idata);
      stallPrev  = ovalid && !oready;
      prevBundle = {olast, 4'b0, olen, odata};
    end
  end

  initial begin
    oready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (oreadyMode)
        0:       oready = 1'b1;
        1:       oready = ~oready;
        default: oready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic applyStimulus(input logic [31:0] v, input bit hold, output int waits);
    idata  = v;
    ivalid = 1'b1;
    waits  = 0;
    @(negedge clk);
    while (!iready && waits <= 100) begin
      waits++;
      @(negedge clk);
    end
    if (waits > 100) checkOutput("accept_timeout", waits, 0);
    @(posedge clk);
    #1;
    if (!hold) ivalid = 1'b0;
  endtask

  // Waits for each byte of one packet; with strict set, bytes must appear on consecutive cycles.
  task automatic collectPacket(input string tag, input logic [39:0] bytes, input int n, input bit strict);
    for (int k = 0; k < n; k++) begin
      int waits;
      waits = 0;
      @(negedge clk);
      while (!(ovalid && oready) && waits < 50) begin
        waits++;
        @(negedge clk);
      end
      if (strict) checkOutput({tag, "_gap"}, waits, 0);
      checkOutput({tag, "_data"}, odata, bytes[8*k +: 8]);
      checkOutput({tag, "_last"}, olast, (k == n - 1));
      checkOutput({tag, "_len"}, olen, n);
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (expQ.size() != 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("drain_empty", expQ.size(), 0);
  endtask

  initial begin
    int w;
    rst    = 1'b1;
    ivalid = 1'b0;
    idata  = '0;
    #2;
    checkOutput("rst_ovalid", ovalid, 0);
    checkOutput("rst_olast", olast, 0);
    checkOutput("rst_odata", odata, 0);
    checkOutput("rst_olen", olen, 0);
    checkOutput("rst_iready", iready, 1);
    ivalid = 1'b1;
    idata  = 32'd77;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    @(negedge clk);
    checkOutput("rst_no_take", ovalid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ovalid", ovalid, 0);

`ifdef LEB128_SIGNED_EN
    applyStimulus(32'hFFFE1DC0, 0, w);
    collectPacket("s_m123456", 40'h00_0078_BBC0, 3, 1);
    applyStimulus(32'd63, 0, w);
    collectPacket("s_63", 40'h3F, 1, 1);
    applyStimulus(32'd64, 0, w);
    collectPacket("s_64", 40'h00C0, 2, 1);
    applyStimulus(32'd0, 1, w);
    applyStimulus(32'h80000000, 0, w);
    checkOutput("b2b_wait", w, 0);
    collectPacket("s_min", 40'h78_8080_8080, 5, 1);
`else
    applyStimulus(32'd624485, 0, w);
    collectPacket("u_624485", 40'h00_0026_8EE5, 3, 1);
    applyStimulus(32'd0, 1, w);
    applyStimulus(32'hFFFFFFFF, 0, w);
    checkOutput("b2b_wait", w, 0);
    collectPacket("u_ffff", 40'h0F_FFFF_FFFF, 5, 1);
`endif

    oreadyMode = 1;
    applyStimulus(32'd300, 0, w);
    collectPacket("bp_300", 40'h02AC, 2, 0);
    drain();

    oreadyMode = 0;
    repeat (2) @(posedge clk);
    #1;
`ifdef LEB128_SIGNED_EN
    applyStimulus(32'h0FFFFFFF, 0, w);
`else
    applyStimulus(32'hFFFFFFFF, 0, w);
`endif
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_ovalid", ovalid, 0);
    checkOutput("midrst_olast", olast, 0);
    checkOutput("midrst_odata", odata, 0);
    checkOutput("midrst_olen", olen, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_ovalid", ovalid, 0);
    applyStimulus(32'd5, 0, w);
    collectPacket("post_5", 40'h05, 1, 1);

    oreadyMode = 2;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] v;
      v = $urandom >> $urandom_range(0, 31);
`ifdef LEB128_SIGNED_EN
      if ($urandom_range(0, 1) == 1) v = ~v;
`endif
      applyStimulus(v, ($urandom_range(0, 2) == 0), w);
      if (!ivalid) repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ivalid = 1'b0;
    oreadyMode = 0;
    drain();
    repeat (3) @(negedge clk);
    checkOutput("last_count", lastCount, wordCount);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
